// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: DQM lane codes, funct3 codes, FSM states.
// Also holds the small decode helpers used at request accept.
// No logic of its own; pure types, constants and combinational functions.
package lsu_pkg;

    localparam logic [1:0] DQM_BYTE = 2'b00;
    localparam logic [1:0] DQM_HALF = 2'b01;
    localparam logic [1:0] DQM_WORD = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    // Illegal encodings and unaligned halves/words are both reported as misaligned.
    function automatic logic access_bad(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = store;
            F3_HU:   bad = store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Sub-word stores that do not start at lane 0 need the rest of the word preserved.
    function automatic logic needs_rmw(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_B) && (off != 2'b00)) || ((f3 == F3_H) && (off == 2'b10));
    endfunction

    function automatic logic [1:0] dqm_for(input logic [2:0] f3);
        logic [1:0] dqm;
        case (f3)
            F3_B, F3_BU: dqm = DQM_BYTE;
            F3_H, F3_HU: dqm = DQM_HALF;
            default:     dqm = DQM_WORD;
        endcase
        return dqm;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, and lane merge for read-modify-write stores.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane from the read word and extend it to 32 bits.
    always_comb begin
        byte_v = rdata_i[{offset_i, 3'b000} +: 8];
        half_v = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_o = {24'h0, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = rdata_i;
        endcase
    end

    // Drop the store data into its lane of the read word, keeping the other lanes.
    always_comb begin
        merge_o = rdata_i;
        case (funct3_i)
            F3_B:    merge_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_H:    merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, aligned sub-word access, RMW for offset sub-word stores.
// Latency: accept->respValid 2 cycles (load/store), 3 cycles (RMW), 1 cycle (misaligned/illegal).
// Backpressure: reqReady only in IDLE; stall held from accept until the response cycle completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    input  logic              reqStore,
    input  logic [2:0]        reqFunct3,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              reqReady,
    output logic              stall,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic              misaligned,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memWE,
    output logic [DATA_W-1:0] memWData,
    output logic [1:0]        memDQM,
    input  logic [DATA_W-1:0] memRData
);

    lsu_state_e        state_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] data_q;
    logic              resp_vld_q;
    logic [DATA_W-1:0] resp_dat_q;
    logic              misal_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        mem_dqm_q;

    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] merge_d;

    lsu_align u_align (
        .funct3_i (f3_q),
        .offset_i (off_q),
        .rdata_i  (memRData),
        .wdata_i  (data_q),
        .load_o   (load_d),
        .merge_o  (merge_d)
    );

    // Access sequencer; every memory-side and response output is a register set on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            data_q      <= '0;
            resp_vld_q  <= 1'b0;
            resp_dat_q  <= '0;
            misal_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_dqm_q   <= DQM_WORD;
        end else begin
            resp_vld_q <= 1'b0;
            misal_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (reqValid) begin
                        off_q      <= reqAddr[1:0];
                        f3_q       <= reqFunct3;
                        data_q     <= reqData;
                        mem_addr_q <= {2'b00, reqAddr[ADDR_W-1:2]};
                        if (access_bad(reqStore, reqFunct3, reqAddr[1:0])) begin
                            // Error response; respData cleared so no stale load leaks out.
                            state_q    <= ST_RESP;
                            resp_vld_q <= 1'b1;
                            misal_q    <= 1'b1;
                            resp_dat_q <= '0;
                        end else if (!reqStore) begin
                            state_q   <= ST_LOAD;
                            mem_dqm_q <= dqm_for(reqFunct3);
                        end else if (needs_rmw(reqFunct3, reqAddr[1:0])) begin
                            state_q   <= ST_RMW_RD;
                            mem_dqm_q <= DQM_WORD;
                        end else begin
                            state_q     <= ST_STORE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= reqData;
                            mem_dqm_q   <= dqm_for(reqFunct3);
                        end
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_RESP;
                    resp_vld_q <= 1'b1;
                    resp_dat_q <= load_d;
                end
                ST_STORE: begin
                    state_q    <= ST_RESP;
                    resp_vld_q <= 1'b1;
                    resp_dat_q <= '0;
                end
                ST_RMW_RD: begin
                    state_q     <= ST_RMW_WR;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= merge_d;
                end
                ST_RMW_WR: begin
                    state_q    <= ST_RESP;
                    resp_vld_q <= 1'b1;
                    resp_dat_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign reqReady   = (state_q == ST_IDLE);
    // In IDLE a valid request is accepted this cycle, so the pipeline must already hold.
    assign stall      = (state_q != ST_IDLE) || reqValid;
    assign respValid  = resp_vld_q;
    assign respData   = resp_dat_q;
    assign misaligned = misal_q;
    assign memAddress = mem_addr_q;
    assign memWE      = mem_we_q;
    assign memWData   = mem_wdata_q;
    assign memDQM     = mem_dqm_q;

endmodule
